// File: rtl/mod_n_down_counter_pkg.sv
// Shared types and helpers for the loadable modulo-N down counter / interval timer.
package mod_n_down_counter_pkg;

    localparam int DEFAULT_MOD = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Out-of-range load values saturate to the top of the count range.
    function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                               input logic [31:0] modulus);
        if (value < modulus) begin
            clamp_load = value;
        end else begin
            clamp_load = modulus - 32'd1;
        end
    endfunction

endpackage

// File: rtl/mod_n_down_counter_if.sv
// Control/status bundle of the down counter; clock and reset stay outside.
interface mod_n_down_counter_if
    import mod_n_down_counter_pkg::*;
#(
    parameter int MOD = DEFAULT_MOD,
    parameter int W   = $clog2(MOD)
);

    logic         sclr;
    logic         load;
    logic [W-1:0] din;
    logic         start;
    logic         en;
    logic         oneshot;
    logic [W-1:0] count;
    logic         borrow;
    logic         busy;
    logic         done;
    logic         load_err;

    modport master (
        output sclr, load, din, start, en, oneshot,
        input  count, borrow, busy, done, load_err
    );

    modport slave (
        input  sclr, load, din, start, en, oneshot,
        output count, borrow, busy, done, load_err
    );

endinterface

// File: rtl/mod_n_down_counter.sv
// Modulo-N down counter: counts a reload value down to 0, then reloads (periodic)
// or parks in DONE (one-shot); emits a registered borrow pulse at terminal count.
module mod_n_down_counter
    import mod_n_down_counter_pkg::*;
#(
    parameter int MOD = DEFAULT_MOD,
    parameter int W   = $clog2(MOD)
) (
    input  logic                clk,
    input  logic                clr_n,
    mod_n_down_counter_if.slave bus
);

    localparam logic [W-1:0] MAX_CNT  = W'(MOD - 1);
    localparam logic [W-1:0] ZERO_CNT = {W{1'b0}};
    localparam logic [W-1:0] ONE_CNT  = W'(1);

    state_e       state_q,  state_d;
    logic [W-1:0] count_q,  count_d;
    logic [W-1:0] reload_q, reload_d;
    logic         borrow_q, borrow_d;
    logic         load_err_q, load_err_d;

    logic [W-1:0] load_v_s;
    logic         din_over_s;

    assign load_v_s   = W'(clamp_load(32'(bus.din), 32'(MOD)));
    assign din_over_s = (32'(bus.din) >= 32'(MOD));

    // Next-state decode; priority sclr > load > start > en.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        reload_d   = reload_q;
        borrow_d   = 1'b0;
        load_err_d = 1'b0;
        if (bus.sclr) begin
            state_d  = ST_IDLE;
            count_d  = ZERO_CNT;
            reload_d = MAX_CNT;
        end else if (bus.load) begin
            count_d    = load_v_s;
            reload_d   = load_v_s;
            load_err_d = din_over_s;
            if (state_q == ST_DONE) begin
                state_d = ST_IDLE;
            end else begin
                state_d = state_q;
            end
        end else if (bus.start) begin
            count_d = reload_q;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!bus.en) begin
                        count_d = count_q;
                    end else if (count_q != ZERO_CNT) begin
                        count_d = count_q - ONE_CNT;
                    end else begin
                        // Terminal count: oneshot is sampled only here.
                        borrow_d = 1'b1;
                        if (bus.oneshot) begin
                            state_d = ST_DONE;
                        end else begin
                            count_d = reload_q;
                        end
                    end
                end
                ST_IDLE: count_d = count_q;
                ST_DONE: count_d = ZERO_CNT;
                default: begin
                    state_d = ST_IDLE;
                    count_d = ZERO_CNT;
                end
            endcase
        end
    end

    // State, count and reload registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= ST_IDLE;
            count_q  <= ZERO_CNT;
            reload_q <= MAX_CNT;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
        end
    end

    // One-cycle registered pulses.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            borrow_q   <= borrow_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.borrow   = borrow_q;
    assign bus.busy     = (state_q == ST_RUN);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_mod_n_down_counter.sv
// Directed self-checking bench for mod_n_down_counter at MOD=12.
module tb_mod_n_down_counter;

    localparam int MOD = 12;
    localparam int W   = 4;

    logic clk;
    logic clr_n;
    int   tests;
    int   errors;

    mod_n_down_counter_if #(.MOD(MOD), .W(W)) bus ();

    mod_n_down_counter #(.MOD(MOD), .W(W)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.sclr = 1'b0; bus.load = 1'b0; bus.start = 1'b0; bus.en = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (bus.count !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.borrow !== 1'b0 || bus.load_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: count=%0d busy=%b done=%b borrow=%b load_err=%b, want 0/0/0/0/0",
                     bus.count, bus.busy, bus.done, bus.borrow, bus.load_err);
        end
    endtask

    task automatic test_reset_mid_run();
        idle_inputs();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tests++;
        if (bus.count !== 4'd11 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_start: count=%0d busy=%b, want 11/1", bus.count, bus.busy);
        end
        bus.en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        tests++;
        if (bus.count !== 4'd6) begin
            errors++;
            $display("FAIL mid_run_count: count=%0d, want 6", bus.count);
        end
        #2 clr_n = 1'b0;
        #1;
        tests++;
        if (bus.count !== 4'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: count=%0d busy=%b, want 0/0", bus.count, bus.busy);
        end
        bus.en = 1'b0;
        tick();
        clr_n = 1'b1;
        tick();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tests++;
        if (bus.count !== 4'd11) begin
            errors++;
            $display("FAIL reload_after_reset: count=%0d, want 11", bus.count);
        end
        bus.sclr = 1'b1; tick(); bus.sclr = 1'b0;
    endtask

    task automatic test_periodic();
        logic [3:0] exp_cnt [8] = '{4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3};
        idle_inputs();
        bus.oneshot = 1'b0;
        bus.load = 1'b1; bus.din = 4'd3; tick(); bus.load = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tests++;
        if (bus.count !== 4'd3 || bus.borrow !== 1'b0) begin
            errors++;
            $display("FAIL periodic_start: count=%0d borrow=%b, want 3/0", bus.count, bus.borrow);
        end
        bus.en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++;
            if (bus.count !== exp_cnt[i] || bus.borrow !== (exp_cnt[i] == 4'd3) || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL periodic_step%0d: count=%0d borrow=%b busy=%b, want %0d/%b/1",
                         i, bus.count, bus.borrow, bus.busy, exp_cnt[i], (exp_cnt[i] == 4'd3));
            end
        end
        bus.en = 1'b0;
        bus.sclr = 1'b1; tick(); bus.sclr = 1'b0;
    endtask

    task automatic test_oneshot();
        idle_inputs();
        bus.oneshot = 1'b1;
        bus.load = 1'b1; bus.din = 4'd2; tick(); bus.load = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        bus.en = 1'b1;
        tick(); tick();
        tests++;
        if (bus.count !== 4'd0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_zero: count=%0d done=%b busy=%b, want 0/0/1", bus.count, bus.done, bus.busy);
        end
        tick();
        tests++;
        if (bus.count !== 4'd0 || bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.borrow !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_done: count=%0d done=%b busy=%b borrow=%b, want 0/1/0/1",
                     bus.count, bus.done, bus.busy, bus.borrow);
        end
        tick();
        tests++;
        if (bus.count !== 4'd0 || bus.done !== 1'b1 || bus.borrow !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_hold: count=%0d done=%b borrow=%b, want 0/1/0", bus.count, bus.done, bus.borrow);
        end
        bus.en = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tests++;
        if (bus.count !== 4'd2 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_rearm: count=%0d done=%b busy=%b, want 2/0/1", bus.count, bus.done, bus.busy);
        end
        bus.oneshot = 1'b0;
        bus.sclr = 1'b1; tick(); bus.sclr = 1'b0;
    endtask

    task automatic test_load_clamp();
        idle_inputs();
        bus.load = 1'b1; bus.din = 4'd13; tick(); bus.load = 1'b0;
        tests++;
        if (bus.count !== 4'd11 || bus.load_err !== 1'b1) begin
            errors++;
            $display("FAIL clamp_13: count=%0d load_err=%b, want 11/1", bus.count, bus.load_err);
        end
        tick();
        tests++;
        if (bus.load_err !== 1'b0) begin
            errors++;
            $display("FAIL clamp_pulse: load_err=%b, want 0", bus.load_err);
        end
        bus.load = 1'b1; bus.din = 4'd11; tick(); bus.load = 1'b0;
        tests++;
        if (bus.count !== 4'd11 || bus.load_err !== 1'b0) begin
            errors++;
            $display("FAIL load_11: count=%0d load_err=%b, want 11/0", bus.count, bus.load_err);
        end
    endtask

    task automatic test_enable_priority();
        logic       en_pat  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] exp_cnt [5] = '{4'd10, 4'd10, 4'd9, 4'd8, 4'd8};
        idle_inputs();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.en = en_pat[i];
            tick();
            tests++;
            if (bus.count !== exp_cnt[i]) begin
                errors++;
                $display("FAIL en_gate%0d: count=%0d, want %0d", i, bus.count, exp_cnt[i]);
            end
        end
        bus.load = 1'b1; bus.din = 4'd7; tick(); bus.load = 1'b0;
        tests++;
        if (bus.count !== 4'd7 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL load_in_run: count=%0d busy=%b, want 7/1", bus.count, bus.busy);
        end
        bus.en = 1'b0;
        bus.sclr = 1'b1; bus.load = 1'b1; bus.din = 4'd4; tick();
        bus.sclr = 1'b0; bus.load = 1'b0;
        tests++;
        if (bus.count !== 4'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL sclr_over_load: count=%0d busy=%b, want 0/0", bus.count, bus.busy);
        end
        bus.load = 1'b1; bus.start = 1'b1; bus.din = 4'd5; tick();
        bus.load = 1'b0; bus.start = 1'b0;
        tests++;
        if (bus.count !== 4'd5 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL load_over_start: count=%0d busy=%b, want 5/0", bus.count, bus.busy);
        end
        bus.en = 1'b1; tick(); bus.en = 1'b0;
        tests++;
        if (bus.count !== 4'd5) begin
            errors++;
            $display("FAIL idle_hold: count=%0d, want 5", bus.count);
        end
    endtask

    task automatic test_reload_zero();
        idle_inputs();
        bus.oneshot = 1'b0;
        bus.load = 1'b1; bus.din = 4'd0; tick(); bus.load = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tests++;
        if (bus.count !== 4'd0 || bus.borrow !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_start: count=%0d borrow=%b busy=%b, want 0/0/1", bus.count, bus.borrow, bus.busy);
        end
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (bus.count !== 4'd0 || bus.borrow !== 1'b1) begin
                errors++;
                $display("FAIL zero_borrow%0d: count=%0d borrow=%b, want 0/1", i, bus.count, bus.borrow);
            end
        end
        bus.en = 1'b0; tick();
        tests++;
        if (bus.borrow !== 1'b0) begin
            errors++;
            $display("FAIL zero_en_off: borrow=%b, want 0", bus.borrow);
        end
    endtask

    initial begin
        tests  = 0;
        errors = 0;
        clr_n  = 1'b0;
        bus.sclr = 1'b0; bus.load = 1'b0; bus.din = 4'd0;
        bus.start = 1'b0; bus.en = 1'b0; bus.oneshot = 1'b0;
        tick();
        test_reset();
        clr_n = 1'b1;
        tick();
        test_reset_mid_run();
        test_periodic();
        test_oneshot();
        test_load_clamp();
        test_enable_priority();
        test_reload_zero();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
